// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, state encoding, field positions and strobe bundle for control_sequencer
package ctrl_pkg;

    localparam logic [4:0] OPC_ADD  = 5'b00000;
    localparam logic [4:0] OPC_SUB  = 5'b00001;
    localparam logic [4:0] OPC_MUL  = 5'b00011;
    localparam logic [4:0] OPC_DIV  = 5'b00100;
    localparam logic [4:0] OPC_NOP  = 5'b11000;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    // Register-select fields inside IR (consumed by the Datapath select-and-encode logic).
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef struct packed {
        logic run;
        logic pc_out;
        logic zhi_out;
        logic zlow_out;
        logic mdr_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic hi_in;
        logic lo_in;
        logic inc_pc;
        logic read;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic alu_add;
        logic alu_sub;
        logic alu_mul;
        logic alu_div;
    } strobes_t;

    function automatic logic is_alu_op(input logic [4:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

    // MUL/DIV produce a 64-bit result and need the extra HI transfer cycle.
    function automatic logic is_wide_op(input logic [4:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational map of (state, opcode) to the Datapath strobe vector
//
// Ports:
//   state   in   current sequencer state
//   opcode  in   opcode governing this cycle (live IR in T3, latched copy afterwards)
//   strobes out  every bus-drive, register-load, select and ALU strobe plus run
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    output strobes_t   strobes
);

    always_comb begin
        strobes     = '0;
        strobes.run = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin
                strobes.pc_out = 1'b1;
                strobes.mar_in = 1'b1;
                strobes.inc_pc = 1'b1;
                strobes.z_in   = 1'b1;
            end
            S_T1: begin
                strobes.zlow_out = 1'b1;
                strobes.pc_in    = 1'b1;
                strobes.read     = 1'b1;
                strobes.mdr_in   = 1'b1;
            end
            S_T2: begin
                strobes.mdr_out = 1'b1;
                strobes.ir_in   = 1'b1;
            end
            S_T3: begin
                // NOP, HALT and unknown opcodes spend T3 idle.
                if (is_alu_op(opcode)) begin
                    strobes.grb   = 1'b1;
                    strobes.r_out = 1'b1;
                    strobes.y_in  = 1'b1;
                end
            end
            S_T4: begin
                strobes.grc     = 1'b1;
                strobes.r_out   = 1'b1;
                strobes.z_in    = 1'b1;
                strobes.alu_add = (opcode == OPC_ADD);
                strobes.alu_sub = (opcode == OPC_SUB);
                strobes.alu_mul = (opcode == OPC_MUL);
                strobes.alu_div = (opcode == OPC_DIV);
            end
            S_T5: begin
                strobes.zlow_out = 1'b1;
                if (is_wide_op(opcode)) begin
                    strobes.lo_in = 1'b1;
                end else begin
                    strobes.gra  = 1'b1;
                    strobes.r_in = 1'b1;
                end
            end
            S_T6: begin
                strobes.zhi_out = 1'b1;
                strobes.hi_in   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute control unit for the Datapath
//
// Ports:
//   Clock, Clear        rising-edge clock, asynchronous active-low reset
//   IR                  instruction register contents from the Datapath
//   Stop                halt request, honoured only at an instruction's last state
//   Run                 high while sequencing (not in RESET or HALT)
//   PCout..DIV          Datapath bus-drive, load, select and ALU strobes
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OPC_MSB = 31
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [DATA_W-1:0] IR,
    input  logic              Stop,
    output logic              Run,
    output logic              PCout,
    output logic              Zhiout,
    output logic              Zlowout,
    output logic              MDRout,
    output logic              MARin,
    output logic              Zin,
    output logic              PCin,
    output logic              MDRin,
    output logic              IRin,
    output logic              Yin,
    output logic              HIin,
    output logic              LOin,
    output logic              IncPC,
    output logic              Read,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              ADD,
    output logic              SUB,
    output logic              MUL,
    output logic              DIV
);

    state_t     state_q;
    logic [4:0] opc_q;
    logic [4:0] opc_ir;
    logic [4:0] opc_cur;
    strobes_t   strobes;
    state_t     instr_end;
    logic       unused_ir;

    assign opc_ir    = IR[OPC_MSB -: 5];
    // Only the opcode field matters here; register fields go straight to the Datapath.
    assign unused_ir = ^IR;

    // IR is valid from T3 on; after the T3 edge the latched copy keeps the
    // sequence immune to later IR changes.
    assign opc_cur   = (state_q == S_T3) ? opc_ir : opc_q;
    assign instr_end = Stop ? S_HALT : S_T0;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_RESET;
            opc_q   <= '0;
        end else begin
            if (state_q == S_T3) begin
                opc_q <= opc_ir;
            end
            case (state_q)
                S_RESET: state_q <= S_T0;
                S_T0:    state_q <= S_T1;
                S_T1:    state_q <= S_T2;
                S_T2:    state_q <= S_T3;
                S_T3: begin
                    if (opc_ir == OPC_HALT) begin
                        state_q <= S_HALT;
                    end else if (is_alu_op(opc_ir)) begin
                        state_q <= S_T4;
                    end else begin
                        state_q <= instr_end;
                    end
                end
                S_T4:    state_q <= S_T5;
                S_T5:    state_q <= is_wide_op(opc_q) ? S_T6 : instr_end;
                S_T6:    state_q <= instr_end;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_RESET;
            endcase
        end
    end

    ctrl_decode u_decode (
        .state   (state_q),
        .opcode  (opc_cur),
        .strobes (strobes)
    );

    assign Run     = strobes.run;
    assign PCout   = strobes.pc_out;
    assign Zhiout  = strobes.zhi_out;
    assign Zlowout = strobes.zlow_out;
    assign MDRout  = strobes.mdr_out;
    assign MARin   = strobes.mar_in;
    assign Zin     = strobes.z_in;
    assign PCin    = strobes.pc_in;
    assign MDRin   = strobes.mdr_in;
    assign IRin    = strobes.ir_in;
    assign Yin     = strobes.y_in;
    assign HIin    = strobes.hi_in;
    assign LOin    = strobes.lo_in;
    assign IncPC   = strobes.inc_pc;
    assign Read    = strobes.read;
    assign Gra     = strobes.gra;
    assign Grb     = strobes.grb;
    assign Grc     = strobes.grc;
    assign Rin     = strobes.r_in;
    assign Rout    = strobes.r_out;
    assign ADD     = strobes.alu_add;
    assign SUB     = strobes.alu_sub;
    assign MUL     = strobes.alu_mul;
    assign DIV     = strobes.alu_div;

endmodule
